// File: rtl/bs_left_pipe.sv
// Pipelined 16-bit left barrel shifter: one register per log stage (1, 2, 4, 8), global stall.
// Optional feature: define BS_LEFT_OVF_EN to add the sticky overflow output `ovf`.
module bs_left_pipe #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   s,
    input  logic             l,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef BS_LEFT_OVF_EN
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] b,
    output logic             busy
);

    if (WIDTH != (1 << SHW)) begin : g_param_check
        $error("bs_left_pipe: WIDTH must equal 2**SHW");
    end

    logic           adv;
    logic [SHW-1:0] valid_vec;

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv && !rst;
    assign busy      = |valid_vec;
    assign out_valid = g_stage[SHW-1].valid_q;
    assign b         = g_stage[SHW-1].data_q;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int AMT = 1 << k;

        logic [WIDTH-1:0] src_data;
        logic             src_valid;
        logic             src_fill;
        logic             src_sel;
        logic [WIDTH-1:0] shifted;
        logic             valid_q;
        logic [WIDTH-1:0] data_q;

        if (k == 0) begin : g_src
            assign src_data  = a;
            assign src_valid = in_valid;
            assign src_fill  = l;
            assign src_sel   = s[0];
        end else begin : g_src
            assign src_data  = g_stage[k-1].data_q;
            assign src_valid = g_stage[k-1].valid_q;
            assign src_fill  = g_stage[k-1].g_res.fill_q;
            assign src_sel   = g_stage[k-1].g_res.res_q[0];
        end

        assign shifted = src_sel ? {src_data[WIDTH-1-AMT:0], {AMT{src_fill}}} : src_data;

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else if (adv) begin
                valid_q <= src_valid;
                data_q  <= shifted;
            end
        end

        assign valid_vec[k] = valid_q;

        // Residual shift bits and the fill bit only travel as far as a later stage needs them.
        if (k < SHW-1) begin : g_res
            localparam int RW = SHW - 1 - k;

            logic [RW-1:0] res_d;
            logic [RW-1:0] res_q;
            logic          fill_q;

            if (k == 0) begin : g_d
                assign res_d = s[SHW-1:1];
            end else begin : g_d
                assign res_d = g_stage[k-1].g_res.res_q[RW:1];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    res_q  <= '0;
                    fill_q <= 1'b0;
                end else if (adv) begin
                    res_q  <= res_d;
                    fill_q <= src_fill;
                end
            end
        end

`ifdef BS_LEFT_OVF_EN
        logic src_ovf;
        logic ovf_q;

        if (k == 0) begin : g_ovf_src
            assign src_ovf = 1'b0;
        end else begin : g_ovf_src
            assign src_ovf = g_stage[k-1].ovf_q;
        end

        // Sticky: once a 1 falls off the MSB in any stage, the beat keeps its flag.
        always_ff @(posedge clk) begin
            if (rst) begin
                ovf_q <= 1'b0;
            end else if (adv) begin
                ovf_q <= src_ovf | (src_sel & (|src_data[WIDTH-1 -: AMT]));
            end
        end
`endif
    end

`ifdef BS_LEFT_OVF_EN
    assign ovf = out_valid & g_stage[SHW-1].ovf_q;
`endif

endmodule

// File: tb/tb_bs_left_pipe.sv
// Scoreboard bench for bs_left_pipe: driver pushes expected results, a monitor pops and compares.
// Also exercises the ovf output when BS_LEFT_OVF_EN is defined.
module tb_bs_left_pipe;

    localparam int WIDTH = 16;
    localparam int SHW   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [SHW-1:0]   s;
    logic             l;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] b;
    logic             busy;
`ifdef BS_LEFT_OVF_EN
    logic             ovf;
`endif

    bs_left_pipe #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .s         (s),
        .l         (l),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef BS_LEFT_OVF_EN
        .ovf       (ovf),
`endif
        .b         (b),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] b;
        logic             ovf;
    } exp_t;

    exp_t exp_q[$];
    int   pop_cyc[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;
    int   cyc          = 0;
    bit   rand_done    = 0;

    // Reference: shift in a 32-bit space, fill the low sh bits with l, then split result / lost bits.
    function automatic exp_t model(input logic [WIDTH-1:0] av, input int sh, input logic lv);
        exp_t        e;
        logic [31:0] wide;
        wide = {16'b0, av} << sh;
        if (lv) wide = wide | ((32'd1 << sh) - 32'd1);
        e.b   = wide[15:0];
        e.ovf = (({16'b0, av} << sh) >> 16) != 32'd0;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_compared++;
        if (act !== req) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] av, input int sh, input logic lv,
                                 output int waited);
        waited = 0;
        @(negedge clk);
        a        = av;
        s        = sh[SHW-1:0];
        l        = lv;
        in_valid = 1'b1;
        #1;
        while (!in_ready) begin
            waited++;
            if (waited > 200) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL accept_timeout: in_ready stuck at 0 for %0d cycles, expected 1", waited);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
        end
        exp_q.push_back(model(av, sh, lv));
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int cnt = 0;
        idle();
        while (exp_q.size() != 0 && cnt < 500) begin
            @(negedge clk);
            cnt++;
        end
        #3;
        checkOutput("drain_empty", exp_q.size(), 0);
    endtask

    // Monitor: every consumed output must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            #2;
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL unexpected_output: got b=0x%0h with no beat outstanding, expected none", b);
                end else begin
                    e = exp_q.pop_front();
                    pop_cyc.push_back(cyc);
                    checkOutput("result_b", b, e.b);
`ifdef BS_LEFT_OVF_EN
                    checkOutput("result_ovf", ovf, e.ovf);
`endif
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   w;
        exp_t e1;

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        s         = '0;
        l         = 1'b0;
        out_ready = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_b", b, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_in_ready_low", in_ready, 0);
        rst = 1'b0;
        #1;
        checkOutput("post_reset_in_ready", in_ready, 1);

        // Basic shift with exact latency.
        $display("[TB] basic latency");
        applyStimulus(16'h1234, 4, 1'b0, w);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #3;
            checkOutput($sformatf("latency_valid_edge%0d", i), out_valid, (i == 4) ? 1 : 0);
        end
        @(negedge clk);
        #3;
        checkOutput("busy_after_consume", busy, 0);

        $display("[TB] fill and extremes");
        applyStimulus(16'h00F0, 3, 1'b1, w);
        applyStimulus(16'h0001, 15, 1'b0, w);
        applyStimulus(16'hABCD, 0, 1'b1, w);
        applyStimulus(16'hFFFF, 15, 1'b1, w);
        applyStimulus(16'h8001, 1, 1'b0, w);
        applyStimulus(16'h0F00, 4, 1'b0, w);
        drain();

        $display("[TB] streaming");
        pop_cyc.delete();
        for (int n = 0; n < 16; n++) begin
            applyStimulus(16'h0001, n, 1'b0, w);
            checkOutput($sformatf("stream_stall_%0d", n), w, 0);
        end
        drain();
        checkOutput("stream_count", pop_cyc.size(), 16);
        if (pop_cyc.size() == 16)
            checkOutput("stream_contiguous", pop_cyc[15] - pop_cyc[0], 15);

        $display("[TB] backpressure");
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        e1 = model(16'h0003, 2, 1'b1);
        applyStimulus(16'h0003, 2, 1'b1, w);
        applyStimulus(16'h0101, 7, 1'b0, w);
        applyStimulus(16'hF00F, 5, 1'b1, w);
        applyStimulus(16'h7FFE, 9, 1'b0, w);
        @(negedge clk);
        a        = 16'h4321;
        s        = 4'd6;
        l        = 1'b1;
        in_valid = 1'b1;
        #1;
        checkOutput("bp_in_ready_full", in_ready, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("bp_hold_valid_%0d", i), out_valid, 1);
            checkOutput($sformatf("bp_b_stable_%0d", i), b, e1.b);
            checkOutput($sformatf("bp_in_ready_%0d", i), in_ready, 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        applyStimulus(16'h4321, 6, 1'b1, w);
        drain();

        $display("[TB] reset mid-flight");
        applyStimulus(16'h1111, 1, 1'b0, w);
        applyStimulus(16'h2222, 2, 1'b1, w);
        applyStimulus(16'h3333, 3, 1'b0, w);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #3;
        checkOutput("midreset_out_valid", out_valid, 0);
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_b", b, 0);
        repeat (10) @(negedge clk);

        $display("[TB] randomized traffic");
        fork
            begin
                while (!rand_done) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle();
            applyStimulus(16'($urandom), int'($urandom_range(0, 15)), 1'($urandom), w);
        end
        idle();
        rand_done = 1;
        repeat (2) @(negedge clk);
        out_ready = 1'b1;
        drain();
        repeat (6) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/bs_left_pipe.md
Name: bs_left_pipe

Overview:
- 16-bit pipelined left barrel shifter; the left-shift counterpart of the team's combinational right shifter `bs`.
- Four log stages (shift by 1, 2, 4, 8), one register per stage. Vacated LSBs are filled with input bit `l`.
- Sits in the ALU shift path behind a valid/ready handshake so the shift can be retimed off the critical path.
- Throughput: one beat per cycle. Latency: 4 cycles.

Parameters:
- WIDTH, 16, data width. Must equal 2**SHW.
- SHW, 4, shift-amount width. Equals the number of pipeline stages.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  input beat present.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand.
- s  input  SHW  left-shift amount, 0..WIDTH-1.
- l  input  1  fill bit shifted into the vacated LSBs.
- out_valid  output  1  `b` holds a result.
- out_ready  input  1  downstream accepts the result.
- b  output  WIDTH  shifted result.
- busy  output  1  at least one stage holds a valid beat.

Behaviour:
- Stages: stage k (k=0..3) holds valid_k, data_k, residual shift bits s[3:k+1] and fill bit l.
  - Stage 0 loads `a` shifted left by 1 if s[0] is set, else `a` unshifted; vacated bits take `l`.
  - Stage k loads data_(k-1) shifted left by 2**k if s[k] is set, else unshifted; vacated LSBs take the carried `l`.
  - Bits shifted past the MSB are discarded.
- Advance rule:
  - adv = !out_valid || out_ready. This is a global stall: every stage moves on adv, nothing moves otherwise.
  - in_ready = adv, combinational.
  - A beat is accepted when in_valid && in_ready at a rising edge.
  - On adv, valid_0 takes in_valid; a cycle with no input enters as a bubble.
  - Bubbles are not collapsed.
- Output:
  - `b` = data_3 and out_valid = valid_3.
  - A beat is consumed when out_valid && out_ready at a rising edge.
- Latency:
  - Counting the accepting edge as edge 1, the result appears on b/out_valid after edge 4.
  - With no stall, a beat accepted every cycle produces a result every cycle.
- busy = OR of valid_0..valid_3.
- Reset (rst=1 at a rising edge):
  - All valid bits, data registers and carried s/l fields clear to 0.
  - Outputs after the edge: out_valid=0, b=0, busy=0. in_ready=1 once rst deasserts.
  - Reset mid-operation drops all in-flight beats; none reappear.
- While rst=1, in_ready is driven 0 and input is ignored.
- Boundaries:
  - s=0 gives b=a.
  - s=15 keeps only a[0] in b[15]; the lower 15 bits are `l`.
- Simultaneous events:
  - Output consume and input accept in the same cycle are legal and required for full throughput.
  - With out_valid=1 and out_ready=0, the pipeline holds all four beats and `b` stays stable until consumed.
- Full condition: four beats held with out_ready=0 gives in_ready=0.
- Ordering: strictly in order; no beat is duplicated or lost.

Optional Feature:
- Macro: BS_LEFT_OVF_EN.
- When defined:
  - Extra output port `ovf` (output, 1 bit).
  - Each stage carries a sticky flag, set when any bit shifted out past the MSB in that stage is 1.
  - `ovf` is aligned with `b`, qualified by out_valid, and resets to 0.
- When undefined: no `ovf` port and no flag registers.

Test Plan:
- Basic shift, out_ready=1: accept a=0x1234, s=4, l=0 → exactly 4 cycles later out_valid=1, b=0x2340; busy=0 one cycle after consume.
- Fill and extremes:
  - a=0x00F0, s=3, l=1 → b=0x0787.
  - a=0x0001, s=15, l=0 → b=0x8000.
  - a=0xABCD, s=0 → b=0xABCD.
- Streaming: 16 back-to-back beats a=0x0001, s=0..15, out_ready=1 → 16 consecutive out_valid cycles, b=0x0001<<n in order, in_ready stays 1.
- Backpressure:
  - Hold out_ready=0 and offer 5 beats → in_ready falls after the 4th accept, and `b` is stable.
  - Release out_ready → all 5 results emerge in order, none lost.
- Reset mid-flight: 3 beats in flight, assert rst one cycle → next cycle out_valid=0, busy=0, b=0, and no stale result ever appears.
- With BS_LEFT_OVF_EN: a=0x8001, s=1, l=0 → b=0x0002, ovf=1; a=0x0F00, s=4 → b=0xF000, ovf=0.
